row_sep: RTL and testbench



---
 rtl/row_sep_pkg.sv | 19 +
 rtl/row_sep_reg.sv | 24 ++
 rtl/row_sep.sv | 83 ++++++++
 tb/tb_row_sep.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/row_sep_pkg.sv
// Shared geometry for the row separator.
// Row index helper wraps modulo the 8-row block.
package row_sep_pkg;

   localparam int PIXEL   = 8;
   localparam int ROW_PIX = 32;
   localparam int ROWS    = 8;
   localparam int ROW_W   = ROW_PIX * PIXEL;
   localparam int BLK_W   = ROWS * ROW_W;

   // 3-bit sum wraps naturally, giving (j + r) mod 8
   function automatic logic [2:0] rot_idx(
      input logic [2:0] j,
      input logic [2:0] r
   );
      return j + r;
   endfunction

endpackage

// File: rtl/row_sep_reg.sv
// One output row register: load on enable, async active-low clear.
module row_sep_reg #(
   parameter int W = 256
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_en,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= '0;
      end else if (i_en) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/row_sep.sv
// Splits a packed 8-row block into eight registered rows, 1-cycle latency.
// Define ROW_SEP_ROT_EN to add the row_rot rotation input.
module row_sep
   import row_sep_pkg::*;
#(
   parameter int PIXEL   = row_sep_pkg::PIXEL,
   parameter int ROW_PIX = row_sep_pkg::ROW_PIX,
   parameter int ROWS    = row_sep_pkg::ROWS
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            in_valid,
   input  logic [ROWS*ROW_PIX*PIXEL-1:0]   ref_ou,
`ifdef ROW_SEP_ROT_EN
   input  logic [2:0]                      row_rot,
`endif
   output logic [ROW_PIX*PIXEL-1:0]        ref_row1,
   output logic [ROW_PIX*PIXEL-1:0]        ref_row2,
   output logic [ROW_PIX*PIXEL-1:0]        ref_row3,
   output logic [ROW_PIX*PIXEL-1:0]        ref_row4,
   output logic [ROW_PIX*PIXEL-1:0]        ref_row5,
   output logic [ROW_PIX*PIXEL-1:0]        ref_row6,
   output logic [ROW_PIX*PIXEL-1:0]        ref_row7,
   output logic [ROW_PIX*PIXEL-1:0]        ref_row8,
   output logic                            out_valid
);

   localparam int RW = ROW_PIX * PIXEL;
   localparam int BW = ROWS * RW;

   generate
      if (ROWS != 8) begin : g_bad_rows
         $error("row_sep: ROWS must be 8");
      end
   endgenerate

   logic [2:0]    w_rot;
   logic [RW-1:0] w_sel [8];
   logic [RW-1:0] w_q   [8];
   logic          r_valid;

`ifdef ROW_SEP_ROT_EN
   assign w_rot = row_rot;
`else
   assign w_rot = 3'd0;
`endif

   // Row 0 sits in the MSBs of the block
   always_comb begin
      for (int j = 0; j < 8; j++) begin
         w_sel[j] = ref_ou[BW-1-RW*int'(rot_idx(3'(j), w_rot)) -: RW];
      end
   end

   for (genvar g = 0; g < 8; g++) begin : g_row
      row_sep_reg #(.W(RW)) u_reg (
         .clk   (clk),
         .rst_n (rst_n),
         .i_en  (in_valid),
         .i_d   (w_sel[g]),
         .o_q   (w_q[g])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
      end else begin
         r_valid <= in_valid;
      end
   end

   assign ref_row1  = w_q[0];
   assign ref_row2  = w_q[1];
   assign ref_row3  = w_q[2];
   assign ref_row4  = w_q[3];
   assign ref_row5  = w_q[4];
   assign ref_row6  = w_q[5];
   assign ref_row7  = w_q[6];
   assign ref_row8  = w_q[7];
   assign out_valid = r_valid;

endmodule

// File: tb/tb_row_sep.sv
// Directed bench for row_sep with a block-level reference model.
// Rotation vectors run only when ROW_SEP_ROT_EN is defined.
module tb_row_sep;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic [2047:0] ref_ou = '0;
   logic [2:0]    row_rot = 3'd0;
   logic [255:0]  ref_row1, ref_row2, ref_row3, ref_row4;
   logic [255:0]  ref_row5, ref_row6, ref_row7, ref_row8;
   logic          out_valid;

   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   row_sep dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .ref_ou    (ref_ou),
`ifdef ROW_SEP_ROT_EN
      .row_rot   (row_rot),
`endif
      .ref_row1  (ref_row1),
      .ref_row2  (ref_row2),
      .ref_row3  (ref_row3),
      .ref_row4  (ref_row4),
      .ref_row5  (ref_row5),
      .ref_row6  (ref_row6),
      .ref_row7  (ref_row7),
      .ref_row8  (ref_row8),
      .out_valid (out_valid)
   );

   logic [255:0] d_row [8];
   assign d_row[0] = ref_row1;
   assign d_row[1] = ref_row2;
   assign d_row[2] = ref_row3;
   assign d_row[3] = ref_row4;
   assign d_row[4] = ref_row5;
   assign d_row[5] = ref_row6;
   assign d_row[6] = ref_row7;
   assign d_row[7] = ref_row8;

   // Reference model: what each output row must hold
   logic [255:0] m_row [8] = '{default: '0};
   logic         m_valid = 1'b0;

   function automatic logic [255:0] in_row(logic [2047:0] b, int k);
      return b[2047-256*k -: 256];
   endfunction

   function automatic int eff_rot();
`ifdef ROW_SEP_ROT_EN
      return int'(row_rot);
`else
      return 0;
`endif
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < 8; j++) m_row[j] = '0;
         m_valid = 1'b0;
      end else begin
         m_valid = in_valid;
         if (in_valid)
            for (int j = 0; j < 8; j++)
               m_row[j] = in_row(ref_ou, (j + eff_rot()) % 8);
      end
   end

   task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int j = 0; j < 8; j++)
            chk($sformatf("model_row%0d", j + 1), d_row[j], m_row[j]);
         chk("model_valid", 256'(out_valid), 256'(m_valid));
      end
   end

   task automatic drive(logic v, logic [2047:0] b, logic [2:0] r);
      @(negedge clk);
      in_valid = v;
      ref_ou   = b;
      row_rot  = r;
   endtask

   logic [2047:0] b_alt;
   logic [2047:0] b_inc;
   logic [2047:0] b_rnd;

   initial begin
      b_alt = {32{32'hFFFFFFFF, 32'h0}};
      for (int k = 0; k < 8; k++)
         b_inc[2047-256*k -: 256] = {32{8'(k + 1)}};

      #2;
      for (int j = 0; j < 8; j++) chk("rst_row", d_row[j], 256'd0);
      chk("rst_valid", 256'(out_valid), 256'd0);
      chk_en = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;

      drive(1'b1, b_alt, 3'd0);
      @(posedge clk); #1;
      chk("alt_row1", ref_row1, {4{64'hFFFFFFFF00000000}});
      chk("alt_row8", ref_row8, {4{64'hFFFFFFFF00000000}});
      chk("alt_valid", 256'(out_valid), 256'd1);

      drive(1'b1, b_inc, 3'd0);
      @(posedge clk); #1;
      chk("inc_row1", ref_row1, {32{8'h01}});
      chk("inc_row4", ref_row4, {32{8'h04}});
      chk("inc_row8", ref_row8, {32{8'h08}});

      for (int i = 0; i < 5; i++) begin
         for (int w = 0; w < 64; w++) b_rnd[32*w +: 32] = $urandom;
         drive(1'b0, b_rnd, 3'd0);
      end
      @(posedge clk); #1;
      chk("hold_row3", ref_row3, {32{8'h03}});
      chk("hold_valid", 256'(out_valid), 256'd0);

      for (int i = 0; i < 6; i++)
         drive(1'b1, (i % 2 == 0) ? b_alt : b_inc, 3'd0);
      @(posedge clk); #1;
      chk("b2b_row2", ref_row2, {32{8'h02}});

`ifdef ROW_SEP_ROT_EN
      drive(1'b1, b_inc, 3'd3);
      @(posedge clk); #1;
      chk("rot3_row1", ref_row1, {32{8'h04}});
      chk("rot3_row8", ref_row8, {32{8'h03}});
      drive(1'b1, b_inc, 3'd7);
      @(posedge clk); #1;
      chk("rot7_row1", ref_row1, {32{8'h08}});
      chk("rot7_row2", ref_row2, {32{8'h01}});
`endif

      drive(1'b1, b_inc, 3'd0);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      for (int j = 0; j < 8; j++) chk("async_row", d_row[j], 256'd0);
      chk("async_valid", 256'(out_valid), 256'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, b_alt, 3'd0);
      drive(1'b0, b_inc, 3'd0);
      @(posedge clk); #1;
      chk("post_rst_row5", ref_row5, {4{64'hFFFFFFFF00000000}});
      @(negedge clk);
      chk_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
